// File: rtl/proc_mem_pkg.sv
// Shared types for the memory request controller: FSM encoding,
// word width, timeout default and the request bundle.
package proc_mem_pkg;

   localparam int XLEN        = 32;
   localparam int TIMEOUT_DEF = 64;

   typedef logic [XLEN-1:0] word_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   typedef struct packed {
      logic  dm;
      logic  we;
      word_t addr;
      word_t wdata;
   } req_t;

   function automatic logic misaligned(word_t a);
      return a[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Memory-side bus between the request controller and the memory.
// Strobes, address and write data flow out; read data and ready flow in.
interface mem_req_ctrl_if;
   import proc_mem_pkg::*;

   word_t addr;
   word_t data_in;
   word_t data_out;
   logic  omem_wr;
   logic  omem_re;
   logic  mem_ready;

   modport master (
      output addr, data_in, omem_wr, omem_re,
      input  data_out, mem_ready
   );

   modport slave (
      input  addr, data_in, omem_wr, omem_re,
      output data_out, mem_ready
   );

endinterface

// File: rtl/mem_timeout_cnt.sv
// Counts BUSY cycles without mem_ready; expired flags the cycle
// whose increment would make the count reach TIMEOUT.
module mem_timeout_cnt #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && cnt != W'(TIMEOUT)) begin
         cnt <= cnt + W'(1);
      end
   end

   assign expired = en && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_req_ctrl.sv
// Arbitrates fetch and data requests onto a single memory port,
// one transaction at a time, with a sticky timeout error.
module mem_req_ctrl
   import proc_mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           if_req,
   input  word_t          if_addr,
   output logic           if_valid,
   output word_t          if_rdata,
   input  logic           dm_req,
   input  logic           dm_we,
   input  word_t          dm_addr,
   input  word_t          dm_wdata,
   output logic           dm_valid,
   output word_t          dm_rdata,
   output logic           dm_misalign,
   output logic           stall,
   output logic           err,
   mem_req_ctrl_if.master mem
);

   state_t state;
   state_t state_n;
   req_t   req;
   logic   acc;
   logic   mis;
   logic   cnt_en;
   logic   expired;
   logic   owner_dm;
   logic   owner_we;

   mem_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (acc),
      .en      (cnt_en),
      .expired (expired)
   );

   always_comb begin
      state_n = state;
      acc     = 1'b0;
      mis     = 1'b0;
      cnt_en  = 1'b0;
      req     = '{dm: 1'b0, we: 1'b0, addr: if_addr, wdata: '0};
      unique case (state)
         S_IDLE: begin
            // dm_valid high here means the misalign pulse of the
            // request still on the port; it must not be re-accepted
            if (dm_req && !dm_valid) begin
               if (misaligned(dm_addr)) begin
                  mis = 1'b1;
               end else begin
                  acc     = 1'b1;
                  req     = '{dm: 1'b1, we: dm_we,
                              addr: dm_addr, wdata: dm_wdata};
                  state_n = S_BUSY;
               end
            end else if (if_req) begin
               acc     = 1'b1;
               state_n = S_BUSY;
            end
         end
         S_BUSY: begin
            cnt_en = !mem.mem_ready;
            if (mem.mem_ready)
               state_n = S_RESP;
            else if (expired)
               state_n = S_ERR;
         end
         S_RESP:  state_n = S_IDLE;
         S_ERR:   state_n = S_ERR;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_IDLE;
         mem.addr    <= '0;
         mem.data_in <= '0;
         mem.omem_wr <= 1'b0;
         mem.omem_re <= 1'b0;
         if_valid    <= 1'b0;
         dm_valid    <= 1'b0;
         dm_misalign <= 1'b0;
         if_rdata    <= '0;
         dm_rdata    <= '0;
         err         <= 1'b0;
         owner_dm    <= 1'b0;
         owner_we    <= 1'b0;
      end else begin
         state       <= state_n;
         if_valid    <= 1'b0;
         dm_valid    <= 1'b0;
         dm_misalign <= 1'b0;
         if (mis) begin
            dm_valid    <= 1'b1;
            dm_misalign <= 1'b1;
         end
         if (acc) begin
            owner_dm    <= req.dm;
            owner_we    <= req.we;
            mem.addr    <= req.addr;
            mem.data_in <= req.wdata;
            mem.omem_wr <= req.we;
            mem.omem_re <= !req.we;
         end
         if (state == S_BUSY && mem.mem_ready) begin
            mem.omem_wr <= 1'b0;
            mem.omem_re <= 1'b0;
            if (owner_dm) begin
               dm_valid <= 1'b1;
               if (!owner_we)
                  dm_rdata <= mem.data_out;
            end else begin
               if_valid <= 1'b1;
               if_rdata <= mem.data_out;
            end
         end
         if (state_n == S_ERR) begin
            mem.omem_wr <= 1'b0;
            mem.omem_re <= 1'b0;
            err         <= 1'b1;
         end
      end
   end

   assign stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

endmodule
